// File: rtl/if_id_skid_pkg.sv
// if_id_skid_pkg: shared constants and types for the IF/ID boundary buffer
package if_id_skid_pkg;
  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam int IFID_DEPTH = 2;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {OP_IDLE = 2'b00, OP_POP = 2'b01, OP_PUSH = 2'b10, OP_BOTH = 2'b11} fifo_op_e;
endpackage

// File: rtl/if_id_store.sv
// if_id_store: DEPTH x W register array, one write port and a combinational read port
module if_id_store #(
  parameter int W = 160,
  parameter int DEPTH = 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_skid.sv
// if_id_skid: IF/ID FIFO buffer with valid/ready handshake, fetch stall and redirect squash
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter int DEPTH = IFID_DEPTH
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_pc_plus_4,
  input  logic [ILEN-1:0]            if_instr,
  output logic                       stall_if,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_pc_plus_4,
  output logic [ILEN-1:0]            id_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int W = 2*XLEN + ILEN;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  logic [W-1:0] rdata;
  fifo_op_e op;
  // ready is derived from registered count only, so a full buffer never accepts
  assign if_ready = count != CW'(DEPTH);
  assign stall_if = ~if_ready;
  assign id_valid = count != '0;
  assign push = if_valid & if_ready & ~flush;
  assign pop = id_valid & id_ready & ~flush;
  assign op = fifo_op_e'({push, pop});
  assign occupancy = count;
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= op == OP_PUSH ? count + CW'(1) : op == OP_POP ? count - CW'(1) : count;
    end
  if_id_store #(.W(W), .DEPTH(DEPTH)) u_store (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .we(push),
    .waddr(wr_ptr),
    .wdata({if_pc, if_pc_plus_4, if_instr}),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  assign id_pc = id_valid ? rdata[W-1 -: XLEN] : '0;
  assign id_pc_plus_4 = id_valid ? rdata[ILEN +: XLEN] : '0;
  assign id_instr = id_valid ? rdata[ILEN-1:0] : ILEN'(INST_NOP);
endmodule
